instenc: RTL

//  Debug/test-side MIPS instruction encoder: takes a mnemonic ID plus operand fields and emits the 32-bit

---
 rtl/instenc_if.sv | 31 +++
 rtl/instenc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instenc_if.sv
// Request/response bundle for the instenc instruction encoder.
// The requester drives the master side; instenc takes the slave side.
interface instenc_if #(
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [5:0]       in_id;
   logic [4:0]       in_rs;
   logic [4:0]       in_rt;
   logic [4:0]       in_rd;
   logic [4:0]       in_shamt;
   logic [15:0]      in_imm;
   logic [25:0]      in_target;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic             out_illegal;
   logic             out_warn;
   logic [CNT_W-1:0] out_count;

   modport master (
      output in_valid, in_id, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, out_ready,
      input  in_ready, out_valid, out_instr, out_illegal, out_warn, out_count
   );

   modport slave (
      input  in_valid, in_id, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, out_ready,
      output in_ready, out_valid, out_instr, out_illegal, out_warn, out_count
   );
endinterface

// File: rtl/instenc.sv
// MIPS instruction encoder: mnemonic ID + operand fields -> 32-bit word, via one encode register and a FIFO.
// Define INSTENC_RANGECHK_EN to flag requests that carry non-zero fields the instruction format ignores.
module instenc #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input logic      clk,
   input logic      rst,
   instenc_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_COP0    = 6'h10;

   typedef struct packed {
      logic        warn;
      logic        illegal;
      logic [31:0] word;
   } ent_t;

   function automatic logic [5:0] r_funct(input logic [5:0] id);
      logic [5:0] f;
      case (id)
         6'd1:    f = 6'h24;
         6'd2:    f = 6'h25;
         6'd3:    f = 6'h26;
         6'd4:    f = 6'h27;
         6'd5:    f = 6'h00;
         6'd6:    f = 6'h02;
         6'd7:    f = 6'h03;
         6'd8:    f = 6'h04;
         6'd9:    f = 6'h06;
         6'd10:   f = 6'h07;
         6'd11:   f = 6'h10;
         6'd12:   f = 6'h11;
         6'd13:   f = 6'h12;
         6'd14:   f = 6'h13;
         6'd15:   f = 6'h20;
         6'd16:   f = 6'h21;
         6'd17:   f = 6'h22;
         6'd18:   f = 6'h23;
         6'd19:   f = 6'h2A;
         6'd20:   f = 6'h2B;
         6'd21:   f = 6'h18;
         6'd22:   f = 6'h19;
         6'd23:   f = 6'h1A;
         6'd24:   f = 6'h1B;
         6'd25:   f = 6'h08;
         6'd26:   f = 6'h09;
         6'd27:   f = 6'h0C;
         6'd28:   f = 6'h0D;
         default: f = 6'h00;
      endcase
      return f;
   endfunction

   function automatic logic [5:0] i_op(input logic [5:0] id);
      logic [5:0] op;
      case (id)
         6'd29:   op = 6'h0C;
         6'd30:   op = 6'h0E;
         6'd31:   op = 6'h0F;
         6'd32:   op = 6'h0D;
         6'd33:   op = 6'h08;
         6'd34:   op = 6'h09;
         6'd35:   op = 6'h0A;
         6'd36:   op = 6'h0B;
         6'd37:   op = 6'h02;
         6'd38:   op = 6'h03;
         6'd39:   op = 6'h04;
         6'd40:   op = 6'h07;
         6'd41:   op = 6'h06;
         6'd42:   op = 6'h05;
         6'd43:   op = 6'h20;
         6'd44:   op = 6'h24;
         6'd45:   op = 6'h21;
         6'd46:   op = 6'h25;
         6'd47:   op = 6'h23;
         6'd48:   op = 6'h28;
         6'd49:   op = 6'h29;
         6'd50:   op = 6'h2B;
         default: op = 6'h00;
      endcase
      return op;
   endfunction

   // REGIMM branches select their variant through the rt slot
   function automatic logic [4:0] regimm_code(input logic [5:0] id);
      logic [4:0] c;
      case (id)
         6'd51:   c = 5'b00001;
         6'd52:   c = 5'b10001;
         6'd54:   c = 5'b10000;
         default: c = 5'b00000;
      endcase
      return c;
   endfunction

   function automatic ent_t encode(input logic [5:0] id, input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] rd, input logic [4:0] sh,
                                   input logic [15:0] imm, input logic [25:0] tgt);
      ent_t e;
      e = '0;
      case (id) inside
         6'd0:                         e.word = 32'h0;
         [6'd1:6'd4], [6'd8:6'd26]:    e.word = {OP_SPECIAL, rs, rt, rd, 5'd0, r_funct(id)};
         [6'd5:6'd7]:                  e.word = {OP_SPECIAL, 5'd0, rt, rd, sh, r_funct(id)};
         6'd27, 6'd28:                 e.word = {OP_SPECIAL, 20'd0, r_funct(id)};
         6'd29, 6'd30, [6'd32:6'd36],
         6'd39, [6'd42:6'd50]:         e.word = {i_op(id), rs, rt, imm};
         6'd31:                        e.word = {i_op(id), 5'd0, rt, imm};
         6'd40, 6'd41:                 e.word = {i_op(id), rs, 5'd0, imm};
         6'd37, 6'd38:                 e.word = {i_op(id), tgt};
         [6'd51:6'd54]:                e.word = {OP_REGIMM, rs, regimm_code(id), imm};
         6'd55:                        e.word = 32'h4200_0018;
         6'd56:                        e.word = {OP_COP0, 5'b00000, rt, rd, 11'd0};
         6'd57:                        e.word = {OP_COP0, 5'b00100, rt, rd, 11'd0};
         default:                      e.illegal = 1'b1;
      endcase
      return e;
   endfunction

`ifdef INSTENC_RANGECHK_EN
   // Fields consumed by each format, as {rs, rt, rd, shamt, imm, target}
   function automatic logic [5:0] used_fields(input logic [5:0] id);
      logic [5:0] u;
      case (id) inside
         [6'd1:6'd4], [6'd8:6'd26]:    u = 6'b111000;
         [6'd5:6'd7]:                  u = 6'b011100;
         6'd29, 6'd30, [6'd32:6'd36],
         6'd39, [6'd42:6'd50]:         u = 6'b110010;
         6'd31:                        u = 6'b010010;
         6'd40, 6'd41:                 u = 6'b100010;
         6'd37, 6'd38:                 u = 6'b000001;
         [6'd51:6'd54]:                u = 6'b100010;
         6'd56, 6'd57:                 u = 6'b011000;
         default:                      u = 6'b000000;
      endcase
      return u;
   endfunction
`endif

   ent_t              enc_d;
   logic              stage_v_q, stage_v_d;
   ent_t              stage_q, stage_d;
   ent_t              mem_q [DEPTH];
   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              empty, full, pop, push, fifo_wr_ok, in_rdy, in_xfer;
   ent_t              head;

   always_comb begin
      enc_d = encode(bus.in_id, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_imm, bus.in_target);
`ifdef INSTENC_RANGECHK_EN
      enc_d.warn = !enc_d.illegal &&
                   (|({bus.in_rs != 5'd0, bus.in_rt != 5'd0, bus.in_rd != 5'd0,
                       bus.in_shamt != 5'd0, bus.in_imm != 16'd0, bus.in_target != 26'd0}
                      & ~used_fields(bus.in_id)));
`endif
   end

   // Handshake and FIFO bookkeeping; in_ready never depends on in_valid
   always_comb begin
      empty      = (wr_ptr_q == rd_ptr_q);
      full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop        = !empty && bus.out_ready;
      fifo_wr_ok = !full || pop;
      push       = stage_v_q && fifo_wr_ok;
      in_rdy     = !stage_v_q || fifo_wr_ok;
      in_xfer    = bus.in_valid && in_rdy;
      stage_v_d  = in_xfer ? 1'b1 : (push ? 1'b0 : stage_v_q);
      stage_d    = in_xfer ? enc_d : stage_q;
      wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
      cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, pop};
   end

   // Encode stage boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_v_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
      end else begin
         stage_v_q <= stage_v_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      stage_q <= stage_d;
   end

   // FIFO storage boundary; cleared so the head reads zero out of reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= stage_q;
      end
   end

   assign head            = mem_q[rd_ptr_q[AW-1:0]];
   assign bus.in_ready    = in_rdy;
   assign bus.out_valid   = !empty;
   assign bus.out_instr   = head.word;
   assign bus.out_illegal = head.illegal;
`ifdef INSTENC_RANGECHK_EN
   assign bus.out_warn    = head.warn;
`else
   assign bus.out_warn    = 1'b0;
`endif
   assign bus.out_count   = cnt_q;
endmodule
